tile_row_renderer: RTL and testbench



---
 rtl/tile_pkg.sv | 48 ++++
 rtl/row_capture_buffer.sv | 66 ++++++
 rtl/tile_row_renderer.sv | 139 +++++++++++++
 tb/tb_tile_row_renderer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and helpers for the snake tile-row renderer: directions,
// colour indices, within-tile region decode and segment connectivity.
package tile_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        BLACK = 2'd0,
        GREEN = 2'd1,
        RED   = 2'd2,
        WHITE = 2'd3
    } colour_e;

    function automatic logic [1:0] region_of(input logic [9:0] offset, input int tile_log2);
        int margin;
        int tile_px;
        margin  = 1 << (tile_log2 - 3);
        tile_px = 1 << tile_log2;
        if (int'(offset) < margin) return 2'd0;
        if (int'(offset) < tile_px - margin) return 2'd1;
        return 2'd2;
    endfunction

    // Connectivity nibble layout is {up, down, left, right}.
    function automatic logic [3:0] dir_bit(input dir_e dir);
        case (dir)
            DIR_UP:   return 4'b1000;
            DIR_DOWN: return 4'b0100;
            DIR_LEFT: return 4'b0010;
            default:  return 4'b0001;
        endcase
    endfunction

    function automatic logic [3:0] conn_bits(input dir_e dir, input dir_e prev_dir,
                                             input logic first, input logic last);
        logic [3:0] conn;
        conn = 4'b0000;
        if (!last) conn = conn | dir_bit(dir);
        if (!first) conn = conn | dir_bit(dir_e'(prev_dir ^ 2'd1));
        return conn;
    endfunction

endpackage

// File: rtl/row_capture_buffer.sv
// Ping-pong row buffers: captures segment connectivity for the next tile row
// while the current row is displayed, and swaps at the top of each tile row.
module row_capture_buffer
    import tile_pkg::*;
#(
    parameter int GRID_W      = 16,
    parameter int SCREEN_ROWS = 15,
    parameter int TW          = 5,
    parameter int XW          = 5,
    parameter int YW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          row_start,
    input  logic [TW-1:0] ty,
    input  logic          seg_valid,
    output logic          seg_ready,
    input  logic [XW-1:0] seg_x,
    input  logic [YW-1:0] seg_y,
    input  logic [1:0]    seg_dir,
    input  logic          seg_first,
    input  logic          seg_last,
    input  logic [XW-1:0] rd_x,
    output logic [3:0]    rd_conn
);

    localparam int NT = GRID_W + 2;

    logic [3:0]    cap_row  [NT];
    logic [3:0]    disp_row [NT];
    logic [YW-1:0] cap_ty;
    logic [YW-1:0] next_ty;
    dir_e          prev_dir;
    logic          swap;
    logic [3:0]    conn;

    // Blanking rows do not swap, so the row-0 capture made during the last
    // visible row survives until the top of the next frame.
    assign swap      = row_start && (int'(ty) < SCREEN_ROWS);
    assign seg_ready = !rst && !swap;
    assign next_ty   = (int'(ty) >= SCREEN_ROWS - 1) ? '0 : YW'(int'(ty) + 1);
    assign conn      = conn_bits(dir_e'(seg_dir), prev_dir, seg_first, seg_last);
    assign rd_conn   = (int'(rd_x) < NT) ? disp_row[rd_x] : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                cap_row[i]  <= 4'b0000;
                disp_row[i] <= 4'b0000;
            end
            cap_ty   <= YW'(1);
            prev_dir <= DIR_UP;
        end else if (swap) begin
            for (int i = 0; i < NT; i++) begin
                disp_row[i] <= cap_row[i];
                cap_row[i]  <= 4'b0000;
            end
            cap_ty <= next_ty;
        end else if (seg_valid && seg_ready) begin
            prev_dir <= dir_e'(seg_dir);
            if (seg_y == cap_ty && int'(seg_x) < NT)
                cap_row[seg_x] <= cap_row[seg_x] | conn;
        end
    end

endmodule

// File: rtl/tile_row_renderer.sv
// Pixel-rate tile renderer for the snake playfield (border, snake, apple).
// Optional build macro CHECKER_BG_EN: dark-grey checkerboard background.
module tile_row_renderer
    import tile_pkg::*;
#(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 13,
    parameter int TILE_LOG2   = 5,
    parameter int SCREEN_ROWS = 15,
    parameter int COLOR_BITS  = 2,
    parameter int FLASH_LOG2  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [9:0]                      px,
    input  logic [9:0]                      py,
    input  logic                            visible,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            seg_valid,
    output logic                            seg_ready,
    input  logic [$clog2(GRID_W+2)-1:0]     seg_x,
    input  logic [$clog2(SCREEN_ROWS)-1:0]  seg_y,
    input  logic [1:0]                      seg_dir,
    input  logic                            seg_first,
    input  logic                            seg_last,
    input  logic [$clog2(GRID_W+2)-1:0]     apple_x,
    input  logic [$clog2(SCREEN_ROWS)-1:0]  apple_y,
    input  logic                            apple_valid,
    input  logic                            failure,
    input  logic                            success,
    output logic [COLOR_BITS-1:0]           r,
    output logic [COLOR_BITS-1:0]           g,
    output logic [COLOR_BITS-1:0]           b,
    output logic                            hsync,
    output logic                            vsync
);

    localparam int XW = $clog2(GRID_W + 2);
    localparam int YW = $clog2(SCREEN_ROWS);
    localparam int TW = 10 - TILE_LOG2;

    logic [TW-1:0]        tx, ty;
    logic [TILE_LOG2-1:0] u, v;
    logic [1:0]           ru, rv;
    logic                 row_start, border, centre, arm, apple_hit, grey;
    logic [3:0]           rd_conn, conn;
    logic [FLASH_LOG2:0]  frame_cnt;
    colour_e              colour;

    function automatic logic [COLOR_BITS-1:0] chan(input logic full, input logic lsb);
        return full ? '1 : COLOR_BITS'(lsb);
    endfunction

    assign tx        = px[9:TILE_LOG2];
    assign ty        = py[9:TILE_LOG2];
    assign u         = px[TILE_LOG2-1:0];
    assign v         = py[TILE_LOG2-1:0];
    assign ru        = region_of(10'(u), TILE_LOG2);
    assign rv        = region_of(10'(v), TILE_LOG2);
    assign row_start = (px == 10'd0) && (v == '0);

    row_capture_buffer #(
        .GRID_W      (GRID_W),
        .SCREEN_ROWS (SCREEN_ROWS),
        .TW          (TW),
        .XW          (XW),
        .YW          (YW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .row_start (row_start),
        .ty        (ty),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_x     (seg_x),
        .seg_y     (seg_y),
        .seg_dir   (seg_dir),
        .seg_first (seg_first),
        .seg_last  (seg_last),
        .rd_x      (XW'(tx)),
        .rd_conn   (rd_conn)
    );

    // Guard against tx aliasing into the buffer after truncation to XW bits.
    assign conn      = (int'(tx) <= GRID_W + 1) ? rd_conn : 4'b0000;
    assign border    = (tx == '0) || (int'(tx) == GRID_W + 1) ||
                       (ty == '0) || (int'(ty) == GRID_H + 1);
    assign centre    = (ru == 2'd1) && (rv == 2'd1);
    assign arm       = (ru == 2'd1 && rv == 2'd0 && conn[3]) ||
                       (ru == 2'd1 && rv == 2'd2 && conn[2]) ||
                       (ru == 2'd0 && rv == 2'd1 && conn[1]) ||
                       (ru == 2'd2 && rv == 2'd1 && conn[0]);
    assign apple_hit = apple_valid && (int'(tx) == int'(apple_x)) && (int'(ty) == int'(apple_y));

    always_ff @(posedge clk) begin
        if (rst) frame_cnt <= '0;
        else if (px == 10'd0 && py == 10'd0) frame_cnt <= frame_cnt + 1'b1;
    end

    always_comb begin
        colour = BLACK;
        grey   = 1'b0;
        if (!visible) begin
            colour = BLACK;
        end else if (border) begin
            if (failure) colour = RED;
            else if (success) colour = frame_cnt[FLASH_LOG2] ? GREEN : WHITE;
            else colour = WHITE;
        end else if ((centre && conn != 4'b0000) || arm) begin
            colour = GREEN;
        end else if (centre && apple_hit) begin
            colour = RED;
        end else begin
`ifdef CHECKER_BG_EN
            grey = tx[0] ^ ty[0];
`else
            grey = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            r     <= chan(colour == RED || colour == WHITE, grey);
            g     <= chan(colour == GREEN || colour == WHITE, grey);
            b     <= chan(colour == WHITE, grey);
            hsync <= hsync_in;
            vsync <= vsync_in;
        end
    end

endmodule

// File: tb/tb_tile_row_renderer.sv
// Bench for tile_row_renderer: vector tables plus hand sequences, outputs
// checked one cycle later through an expectation queue.
module tb_tile_row_renderer;

    localparam logic [5:0] C_BLACK = 6'b000000;
    localparam logic [5:0] C_WHITE = 6'b111111;
    localparam logic [5:0] C_GREEN = 6'b001100;
    localparam logic [5:0] C_RED   = 6'b110000;
    localparam logic [5:0] C_GREY  = 6'b010101;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px, py;
    logic       visible, hsync_in, vsync_in;
    logic       seg_valid, seg_ready, seg_first, seg_last;
    logic [4:0] seg_x, apple_x;
    logic [3:0] seg_y, apple_y;
    logic [1:0] seg_dir;
    logic       apple_valid, failure, success;
    logic [1:0] r, g, b;
    logic       hsync, vsync;

    typedef struct {
        logic [9:0] x, y;
        logic vis, hs, vs, fail, succ;
        logic [4:0] ax;
        logic [3:0] ay;
        logic av;
        logic [5:0] expv;
        string nm;
    } vec_t;

    typedef struct {
        logic [5:0] rgb;
        logic hs, vs;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   frame_starts = 0;

    always #5 clk = ~clk;

    tile_row_renderer dut (
        .clk(clk), .rst(rst), .px(px), .py(py), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_x(seg_x), .seg_y(seg_y),
        .seg_dir(seg_dir), .seg_first(seg_first), .seg_last(seg_last),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .failure(failure), .success(success),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    function automatic vec_t mk(input int x, input int y, input logic [5:0] expv, input string nm,
                                input logic fail = 1'b0, input logic succ = 1'b0,
                                input int ax = 0, input int ay = 0, input logic av = 1'b0,
                                input logic vis = 1'b1);
        vec_t t;
        t.x = 10'(x); t.y = 10'(y); t.vis = vis;
        t.hs = t.x[1]; t.vs = t.y[3];
        t.fail = fail; t.succ = succ;
        t.ax = 5'(ax); t.ay = 4'(ay); t.av = av;
        t.expv = expv; t.nm = nm;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        px = t.x; py = t.y; visible = t.vis; hsync_in = t.hs; vsync_in = t.vs;
        failure = t.fail; success = t.succ;
        apple_x = t.ax; apple_y = t.ay; apple_valid = t.av;
        seg_valid = 1'b0;
        if (t.x == 10'd0 && t.y == 10'd0) frame_starts++;
        sb.push_back('{t.expv, t.hs, t.vs, t.nm});
    endtask

    task automatic beat(input int x, input int y, input int sx, input int sy, input int d,
                        input logic f, input logic l, input logic rdy, input string nm);
        @(negedge clk);
        px = 10'(x); py = 10'(y); visible = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        failure = 1'b0; success = 1'b0; apple_valid = 1'b0;
        seg_valid = 1'b1; seg_x = 5'(sx); seg_y = 4'(sy); seg_dir = 2'(d);
        seg_first = f; seg_last = l;
        sb.push_back('{C_BLACK, 1'b1, 1'b1, nm});
        #1 chk({nm, "_ready"}, {7'd0, seg_ready}, {7'd0, rdy});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            checks++;
            if ({r, g, b} !== cur.rgb) begin
                errors++;
                $display("FAIL %s: rgb=%b, expected %b", cur.nm, {r, g, b}, cur.rgb);
            end
            checks++;
            if ({hsync, vsync} !== {cur.hs, cur.vs}) begin
                errors++;
                $display("FAIL %s_sync: hv=%b, expected %b", cur.nm, {hsync, vsync}, {cur.hs, cur.vs});
            end
        end
    end

    initial begin
        rst = 1'b1; px = 10'd40; py = 10'd40; visible = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        seg_valid = 1'b1; seg_x = 5'd1; seg_y = 4'd1; seg_dir = 2'd3; seg_first = 1'b1; seg_last = 1'b0;
        apple_x = 5'd1; apple_y = 4'd1; apple_valid = 1'b1; failure = 1'b0; success = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", {2'b00, r, g, b}, 8'd0);
        chk("rst_sync", {6'd0, hsync, vsync}, 8'd3);
        chk("rst_ready", {7'd0, seg_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b0; seg_valid = 1'b0;

        // Empty frame: border white, interior and off-grid black.
        tbl.push_back(mk(0, 0, C_WHITE, "corner"));
        tbl.push_back(mk(100, 0, C_WHITE, "top"));
        tbl.push_back(mk(40, 40, C_BLACK, "interior"));
        tbl.push_back(mk(549, 100, C_WHITE, "right"));
        tbl.push_back(mk(100, 451, C_WHITE, "bottom"));
        tbl.push_back(mk(160, 432, C_BLACK, "last_in_row"));
        tbl.push_back(mk(100, 200, C_BLACK, "blank", 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(620, 100, C_BLACK, "offgrid"));
        foreach (tbl[i]) apply(tbl[i]);

        // Two joined segments captured during row 3, drawn on row 4.
        apply(mk(0, 96, C_WHITE, "swap3"));
        beat(100, 100, 6, 5, 1, 1'b0, 1'b0, 1'b1, "drop");
        beat(100, 100, 3, 4, 3, 1'b1, 1'b0, 1'b1, "b0");
        beat(100, 100, 4, 4, 2, 1'b0, 1'b1, 1'b1, "b1");
        apply(mk(0, 128, C_WHITE, "swap4"));
        tbl.delete();
        tbl.push_back(mk(112, 144, C_GREEN, "t3_centre"));
        tbl.push_back(mk(124, 144, C_GREEN, "t3_right_arm"));
        tbl.push_back(mk(130, 144, C_GREEN, "t4_left_arm"));
        tbl.push_back(mk(144, 144, C_GREEN, "t4_centre"));
        tbl.push_back(mk(158, 144, C_BLACK, "t4_right"));
        tbl.push_back(mk(97, 144, C_BLACK, "t3_left"));
        tbl.push_back(mk(112, 129, C_BLACK, "t3_up"));
        tbl.push_back(mk(124, 129, C_BLACK, "t3_corner"));
        tbl.push_back(mk(208, 144, C_BLACK, "t6_dropped"));
        foreach (tbl[i]) apply(tbl[i]);

        // Beat offered in the swap cycle is held, then lands in row 6.
        beat(0, 160, 5, 6, 0, 1'b1, 1'b0, 1'b0, "hs_swap");
        beat(176, 176, 5, 6, 0, 1'b1, 1'b0, 1'b1, "hs_next");
        apply(mk(176, 176, C_BLACK, "row5_empty"));
        apply(mk(0, 192, C_WHITE, "swap6"));
        apply(mk(176, 208, C_GREEN, "r6_centre"));
        apply(mk(176, 193, C_GREEN, "r6_up_arm"));
        apply(mk(176, 222, C_BLACK, "r6_down"));

        // Mid-line reset discards the displayed row.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("mid_rst_ready", {7'd0, seg_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        frame_starts = 0;
        apply(mk(176, 208, C_BLACK, "post_rst_centre"));
        apply(mk(176, 193, C_BLACK, "post_rst_arm"));

        // Apple versus snake on row 5.
        apply(mk(0, 128, C_WHITE, "swap4b"));
        beat(100, 130, 5, 5, 3, 1'b1, 1'b0, 1'b1, "apple_seg");
        apply(mk(0, 160, C_WHITE, "swap5"));
        tbl.delete();
        tbl.push_back(mk(176, 176, C_GREEN, "apple_under_snake", 0, 0, 5, 5, 1));
        tbl.push_back(mk(190, 176, C_GREEN, "snake_arm", 0, 0, 5, 5, 1));
        tbl.push_back(mk(240, 176, C_RED, "apple_centre", 0, 0, 7, 5, 1));
        tbl.push_back(mk(225, 176, C_BLACK, "apple_margin", 0, 0, 7, 5, 1));
        tbl.push_back(mk(240, 178, C_BLACK, "apple_invalid", 0, 0, 7, 5, 0));
        tbl.push_back(mk(5, 40, C_RED, "brd_fail_succ", 1, 1));
        tbl.push_back(mk(5, 40, C_RED, "brd_fail", 1, 0));
        tbl.push_back(mk(5, 40, C_WHITE, "brd_idle", 0, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // Success flash follows bit 4 of the frame count.
        for (int k = 0; k < 5; k++) begin
            apply(mk(5, 40, (((frame_starts >> 4) & 1) != 0) ? C_GREEN : C_WHITE, "brd_success", 0, 1));
            for (int p = 0; p < 8; p++) apply(mk(0, 0, C_BLACK, "frame_pulse", 0, 0, 0, 0, 0, 0));
        end

`ifdef CHECKER_BG_EN
        apply(mk(48, 80, C_GREY, "chk_odd"));
`else
        apply(mk(48, 80, C_BLACK, "chk_odd"));
`endif
        apply(mk(80, 80, C_BLACK, "chk_even"));

        repeat (2) @(posedge clk);
        #2 chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
